// File: rtl/approx_sklansky_pipe_pkg.sv
// ---------------------------------------------------------------------------
// approx_sklansky_pipe_pkg
//
// Shared definitions for the approximate Sklansky adder pipeline.
//   pg_t         : per-bit propagate/generate pair
//   MODE_EXACT   : mode value selecting the exact sum
//   MODE_APPROX  : mode value selecting the approximate sum
//   make_pg()    : builds the pg pair of one operand bit position
// ---------------------------------------------------------------------------
package approx_sklansky_pipe_pkg;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   localparam logic MODE_EXACT  = 1'b0;
   localparam logic MODE_APPROX = 1'b1;

   function automatic pg_t make_pg(input logic a_bit, input logic b_bit);
      pg_t r;
      r.p = a_bit ^ b_bit;
      r.g = a_bit & b_bit;
      return r;
   endfunction

endpackage

// File: rtl/approx_sklansky_pipe_prefix_net.sv
// ---------------------------------------------------------------------------
// sklansky_prefix_net
//
// Sklansky (divide-and-conquer) parallel-prefix carry network.
// Produces every carry of a WIDTH-bit segment from its per-bit
// propagate/generate terms and the carry entering bit 0 of the segment.
//
// Parameters
//   WIDTH    : segment width in bits (>= 1)
// Ports
//   p_i      in  [WIDTH-1:0]  per-bit propagate
//   g_i      in  [WIDTH-1:0]  per-bit generate
//   seed_i   in               carry into bit 0 of the segment
//   carry_o  out [WIDTH:0]    carry_o[i] = carry into bit i,
//                             carry_o[WIDTH] = carry out of the segment
// ---------------------------------------------------------------------------
module sklansky_prefix_net
   import approx_sklansky_pipe_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] p_i,
   input  logic [WIDTH-1:0] g_i,
   input  logic             seed_i,
   output logic [WIDTH:0]   carry_o
);

   localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

   // Each level doubles the span of every group. At level lvl, a bit whose
   // index has bit lvl set merges with the top bit of the lower half of its
   // 2^(lvl+1) block, so after LEVELS levels every bit i covers [0..i].
   always_comb begin
      logic [WIDTH-1:0] g_cur;
      logic [WIDTH-1:0] p_cur;
      logic [WIDTH-1:0] g_nxt;
      logic [WIDTH-1:0] p_nxt;

      // NOTE: every variable gets a value before any conditional update, so
      // no path through the block leaves one unassigned (no latches).
      g_cur = g_i;
      p_cur = p_i;
      g_nxt = g_i;
      p_nxt = p_i;
      carry_o = '0;

      for (int lvl = 0; lvl < LEVELS; lvl++) begin
         g_nxt = g_cur;
         p_nxt = p_cur;
         for (int i = 0; i < WIDTH; i++) begin
            if (((i >> lvl) & 1) == 1) begin
               g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[((i >> lvl) << lvl) - 1]);
               p_nxt[i] = p_cur[i] & p_cur[((i >> lvl) << lvl) - 1];
            end
         end
         g_cur = g_nxt;
         p_cur = p_nxt;
      end

      // Fold the segment seed into each group term to get the carries.
      carry_o[0] = seed_i;
      for (int i = 0; i < WIDTH; i++) begin
         carry_o[i+1] = g_cur[i] | (p_cur[i] & seed_i);
      end
   end

endmodule

// File: rtl/approx_sklansky_pipe.sv
// ---------------------------------------------------------------------------
// approx_sklansky_pipe
//
// Two-stage pipelined adder offering an exact Sklansky sum and an
// approximate sum whose low APPROX_K carries do not propagate. Also flags
// beats where the approximation is wrong and counts them (saturating).
//
// Stage S1 registers the operands, carry-in, mode and per-bit p/g.
// Stage S2 registers sum, cout and err. Valid/ready handshake on both sides.
//
// Parameters
//   WIDTH     operand width (4..64)
//   APPROX_K  number of low bits with non-propagating carries (0..WIDTH)
//   CNT_W     error counter width
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle when in_valid is high
//   a, b       in   operands
//   cin        in   carry-in
//   mode       in   0 = exact, 1 = approximate (sampled with the beat)
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts the result
//   sum        out  result sum
//   cout       out  carry out of bit WIDTH-1
//   err        out  approximate result differs from exact for this beat
//   err_cnt    out  saturating count of delivered beats with err=1
//   cnt_clr    in   synchronous clear of err_cnt
// ---------------------------------------------------------------------------
module approx_sklansky_pipe
   import approx_sklansky_pipe_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int APPROX_K = 8,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             cnt_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic s1_valid_q;
   logic out_valid_q;
   logic s2_adv;
   logic s1_load;

   // S2 can take a new beat when it is empty or its result leaves now;
   // S1 can take a new beat when it is empty or its beat moves into S2.
   assign s2_adv   = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_adv;
   assign s1_load  = in_valid && in_ready;

   // ------------------------------------------------------------------
   // Stage 1
   // ------------------------------------------------------------------
   pg_t  [WIDTH-1:0] pg_d;
   pg_t  [WIDTH-1:0] pg_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   logic             mode_q;

   always_comb begin
      pg_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pg_d[i] = make_pg(a[i], b[i]);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge value of every other register.
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
      end
   end

   // NOTE: the S1 payload is qualified by s1_valid_q and is never observed
   // while invalid, so it carries no reset and only loads on acceptance.
   always_ff @(posedge clk) begin
      if (s1_load) begin
         a_q    <= a;
         b_q    <= b;
         cin_q  <= cin;
         mode_q <= mode;
         pg_q   <= pg_d;
      end
   end

   // ------------------------------------------------------------------
   // Exact path: full-width Sklansky network on the registered p/g
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] ex_p;
   logic [WIDTH-1:0] ex_g;
   logic [WIDTH:0]   ex_c;
   logic [WIDTH-1:0] ex_sum;
   logic             ex_cout;

   always_comb begin
      ex_p = '0;
      ex_g = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ex_p[i] = pg_q[i].p;
         ex_g[i] = pg_q[i].g;
      end
   end

   sklansky_prefix_net #(
      .WIDTH (WIDTH)
   ) u_exact_net (
      .p_i     (ex_p),
      .g_i     (ex_g),
      .seed_i  (cin_q),
      .carry_o (ex_c)
   );

   assign ex_sum  = ex_p ^ ex_c[WIDTH-1:0];
   assign ex_cout = ex_c[WIDTH];

   // ------------------------------------------------------------------
   // Approximate path
   // The approximate path rebuilds p/g from the registered operands;
   // these terms are identical to pg_q and are shared after synthesis.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0]  ap_p;
   logic [WIDTH-1:0]  ap_g;
   logic [APPROX_K:0] lo_c;
   logic [WIDTH:0]    ap_c;
   logic [WIDTH-1:0]  ap_sum;
   logic              ap_cout;

   assign ap_p = a_q ^ b_q;
   assign ap_g = a_q & b_q;

   // Low segment: carry into bit i (1..APPROX_K) is just the generate of
   // bit i-1; nothing ripples. lo_c[APPROX_K] seeds the upper segment.
   always_comb begin
      lo_c    = '0;
      lo_c[0] = cin_q;
      for (int i = 1; i <= APPROX_K; i++) begin
         lo_c[i] = ap_g[i-1];
      end
   end

   if (APPROX_K < WIDTH) begin : g_upper
      logic [WIDTH-APPROX_K:0] up_c;

      sklansky_prefix_net #(
         .WIDTH (WIDTH - APPROX_K)
      ) u_upper_net (
         .p_i     (ap_p[WIDTH-1:APPROX_K]),
         .g_i     (ap_g[WIDTH-1:APPROX_K]),
         .seed_i  (lo_c[APPROX_K]),
         .carry_o (up_c)
      );

      // up_c[0] equals lo_c[APPROX_K], so the upper net owns that carry.
      if (APPROX_K > 0) begin : g_split
         assign ap_c = {up_c, lo_c[APPROX_K-1:0]};
      end else begin : g_exact_equiv
         assign ap_c = up_c;
      end
   end else begin : g_all_approx
      assign ap_c = lo_c;
   end

   assign ap_sum  = ap_p ^ ap_c[WIDTH-1:0];
   assign ap_cout = ap_c[WIDTH];

   // ------------------------------------------------------------------
   // Result selection and stage 2
   // ------------------------------------------------------------------
   logic             approx_sel;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             err_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             err_q;

   assign approx_sel = (mode_q == MODE_APPROX);
   assign sum_d      = approx_sel ? ap_sum  : ex_sum;
   assign cout_d     = approx_sel ? ap_cout : ex_cout;
   assign err_d      = approx_sel && ({ap_cout, ap_sum} != {ex_cout, ex_sum});

   // S2 only moves when it may advance, which keeps the outputs stable
   // while a result is stalled by out_ready=0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         err_q       <= 1'b0;
      end else if (s2_adv) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            err_q  <= err_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Error counter: counts delivered erroring beats, saturates at max.
   // A clear coinciding with a counted transfer leaves a count of one.
   // ------------------------------------------------------------------
   logic             err_inc;
   logic [CNT_W-1:0] err_cnt_d;
   logic [CNT_W-1:0] err_cnt_q;

   assign err_inc = out_valid_q && out_ready && err_q;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (cnt_clr) begin
         err_cnt_d = err_inc ? CNT_W'(1) : '0;
      end else if (err_inc && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign err       = err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_approx_sklansky_pipe.sv
// ---------------------------------------------------------------------------
// tb_approx_sklansky_pipe
//
// Self-checking bench for approx_sklansky_pipe (WIDTH=16, APPROX_K=8).
// Accepted beats push their expected result into a queue; a monitor pops
// and compares on every result transfer. Directed steps cover reset,
// latency, backpressure, counter saturation/clear and mid-flight reset.
// ---------------------------------------------------------------------------
module tb_approx_sklansky_pipe;

   localparam int WIDTH    = 16;
   localparam int APPROX_K = 8;
   localparam int CNT_W    = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             err;
   logic [CNT_W-1:0] err_cnt;
   logic             cnt_clr;

   always #5 clk = ~clk;

   approx_sklansky_pipe #(
      .WIDTH    (WIDTH),
      .APPROX_K (APPROX_K),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .err       (err),
      .err_cnt   (err_cnt),
      .cnt_clr   (cnt_clr)
   );

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk_exp(input logic [WIDTH-1:0] s, input logic c, input logic e);
      exp_t r;
      r.sum  = s;
      r.cout = c;
      r.err  = e;
      return r;
   endfunction

   // Ripple reference: exact sum by integer add; approximate sum by a bit
   // loop whose carry is just the generate bit below APPROX_K.
   function automatic exp_t model(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                  input logic ci, input logic mi);
      logic [WIDTH:0]   ex;
      logic [WIDTH-1:0] s;
      logic             c;
      exp_t             r;
      ex = {1'b0, ai} + {1'b0, bi} + {{WIDTH{1'b0}}, ci};
      s  = '0;
      c  = ci;
      for (int i = 0; i < WIDTH; i++) begin
         s[i] = ai[i] ^ bi[i] ^ c;
         if (i < APPROX_K) c = ai[i] & bi[i];
         else              c = (ai[i] & bi[i]) | ((ai[i] ^ bi[i]) & c);
      end
      if (mi) r = mk_exp(s, c, ({c, s} != ex));
      else    r = mk_exp(ex[WIDTH-1:0], ex[WIDTH], 1'b0);
      return r;
   endfunction

   // Present a beat and wait (bounded) for it to be accepted. Leaves
   // in_valid high and returns just after the accepting edge.
   task automatic send(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                       input logic ci, input logic mi, input exp_t ev);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      a        = ai;
      b        = bi;
      cin      = ci;
      mode     = mi;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(ev);
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("accept_timeout", 64'(in_ready), 64'(1));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard monitor: compare every result transfer against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("stale_out", 64'(out_valid), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("sum",  64'(sum),  64'(e.sum));
            check("cout", 64'(cout), 64'(e.cout));
            check("err",  64'(err),  64'(e.err));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t             b1v;
      bit               seen;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      logic             rm;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      mode      = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_err_cnt",   64'(err_cnt),   64'(0));
      check("rst_sum",       64'(sum),       64'(0));
      check("rst_cout",      64'(cout),      64'(0));
      check("rst_err",       64'(err),       64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

      // Approximate error case, then the same operands exact
      send(16'h00FF, 16'h0001, 1'b0, 1'b1, mk_exp(16'h00FC, 1'b0, 1'b1));
      idle(4);
      check("cnt_after_err", 64'(err_cnt), 64'(1));
      send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk_exp(16'h0100, 1'b0, 1'b0));
      idle(4);
      check("cnt_after_exact", 64'(err_cnt), 64'(1));

      // Approximate with no low-segment carries: no error
      send(16'h0F00, 16'h0100, 1'b0, 1'b1, mk_exp(16'h1000, 1'b0, 1'b0));
      idle(4);

      // Full-width carry and two-cycle latency
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk_exp(16'h0000, 1'b1, 1'b0));
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_cycle1_valid", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("lat_cycle2_valid", 64'(out_valid), 64'(1));
      @(posedge clk);
      #1;
      idle(2);

      // Random back-to-back beats in both modes
      for (int n = 0; n < 24; n++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom);
         rm = 1'($urandom);
         send(ra, rb, rc, rm, model(ra, rb, rc, rm));
      end
      idle(4);
      check("rand_drained", 64'(exp_q.size()), 64'(0));

      // Backpressure: two beats held, third refused, outputs stable
      out_ready = 1'b0;
      b1v = model(16'h1234, 16'h0FCD, 1'b1, 1'b1);
      send(16'h1234, 16'h0FCD, 1'b1, 1'b1, b1v);
      send(16'h8000, 16'h8000, 1'b0, 1'b0, model(16'h8000, 16'h8000, 1'b0, 1'b0));
      in_valid = 1'b1;
      a        = 16'h00F0;
      b        = 16'h0010;
      cin      = 1'b0;
      mode     = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("bp_in_ready_low", 64'(in_ready),  64'(0));
         check("bp_hold_valid",   64'(out_valid), 64'(1));
         check("bp_hold_sum",     64'(sum),       64'(b1v.sum));
         check("bp_hold_err",     64'(err),       64'(b1v.err));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(16'h00F0, 16'h0010, 1'b0, 1'b1, model(16'h00F0, 16'h0010, 1'b0, 1'b1));
      idle(5);
      check("bp_all_delivered", 64'(exp_q.size()), 64'(0));

      // Counter clear on its own
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      check("clr_alone", 64'(err_cnt), 64'(0));
      @(posedge clk);
      #1;

      // Saturation
      for (int n = 0; n < 65535; n++) begin
         send(16'h00FF, 16'h0001, 1'b0, 1'b1, mk_exp(16'h00FC, 1'b0, 1'b1));
      end
      idle(4);
      check("sat_reach", 64'(err_cnt), 64'(16'hFFFF));
      send(16'h00FF, 16'h0001, 1'b0, 1'b1, mk_exp(16'h00FC, 1'b0, 1'b1));
      idle(4);
      check("sat_hold", 64'(err_cnt), 64'(16'hFFFF));

      // Clear coinciding with an erroring transfer
      send(16'h00FF, 16'h0001, 1'b0, 1'b1, mk_exp(16'h00FC, 1'b0, 1'b1));
      in_valid = 1'b0;
      seen     = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      if (!seen) check("clr_wait_timeout", 64'(out_valid), 64'(1));
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      @(negedge clk);
      check("clr_with_err", 64'(err_cnt), 64'(1));
      @(posedge clk);
      #1;

      // Reset with two beats in flight
      out_ready = 1'b0;
      send(16'h00FF, 16'h0001, 1'b0, 1'b1, mk_exp(16'h00FC, 1'b0, 1'b1));
      send(16'h0FFF, 16'h0001, 1'b0, 1'b0, mk_exp(16'h1000, 1'b0, 1'b0));
      in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      @(negedge clk);
      check("mid_rst_valid",   64'(out_valid), 64'(0));
      check("mid_rst_err_cnt", 64'(err_cnt),   64'(0));
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'(1));
      repeat (6) begin
         check("post_rst_no_stale", 64'(out_valid), 64'(0));
         @(negedge clk);
      end
      check("final_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
